// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART boot loader: image header value and FSM encodings.
package uart_imem_loader_pkg;

    localparam logic [7:0] LOADER_HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // States in which an image is partially received and errors abort it.
    function automatic logic is_loading(input loader_state_e s);
        return (s == CNT_LO) || (s == CNT_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver on an already-synchronized line; one-cycle byte_valid
// or frame_err pulse per frame, data LSB first.
module uart_rx_byte
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_async,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          rx_prev;
    logic          valid_n, ferr_n;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_prev    <= 1'b1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            rx_prev    <= rx_sync;
            byte_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    // Edge-triggered start so a held-low break after a bad stop bit is not re-read.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_M1) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_BITS: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else bit_idx_n = bit_idx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    valid_n = rx_sync;
                    ferr_n  = !rx_sync;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign byte_data = shift;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a checksummed program image over UART, writes it into
// imem word by word and holds the core in reset until a good image arrives.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int ADDR_WIDTH   = 12,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                  clk,
    input  logic                  rst_async,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output loader_state_e         loader_state
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TOW          = $clog2(TO_CYCLES + 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    generate
        if (CLKS_PER_BIT < 8) begin : g_baud_check
            $error("uart_imem_loader: CLK_HZ/BAUD must be at least 8");
        end
    endgenerate

    logic       rx_meta, rx_sync;
    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_async  (rst_async),
        .rx_sync    (rx_sync),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_e         state, state_n;
    logic [7:0]            cnt_lo, cnt_lo_n;
    logic [16:0]           words_left, words_left_n;
    logic [1:0]            byte_idx, byte_idx_n;
    logic [23:0]           word_asm, word_asm_n;
    logic [7:0]            xor_acc, xor_acc_n;
    logic [TOW-1:0]        to_cnt;
    logic                  we_n, done_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [31:0]           wdata_n;
    logic [16:0]           count;

    assign count = {1'b0, byte_data, cnt_lo};

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state      <= IDLE;
            cnt_lo     <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word_asm   <= '0;
            xor_acc    <= '0;
            to_cnt     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_done  <= 1'b0;
            cpu_hold   <= 1'b1;
            load_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt_lo     <= cnt_lo_n;
            words_left <= words_left_n;
            byte_idx   <= byte_idx_n;
            word_asm   <= word_asm_n;
            xor_acc    <= xor_acc_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
            load_done  <= done_n;
            cpu_hold   <= (state_n != RUN);
            load_err   <= (state_n == ERR);
            if (byte_valid) to_cnt <= TOW'(TO_CYCLES);
            else if (to_cnt != '0) to_cnt <= to_cnt - 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_lo_n     = cnt_lo;
        words_left_n = words_left;
        byte_idx_n   = byte_idx;
        word_asm_n   = word_asm;
        xor_acc_n    = xor_acc;
        we_n         = 1'b0;
        done_n       = 1'b0;
        wdata_n      = mem_wdata;
        addr_n       = mem_we ? mem_addr + 1'b1 : mem_addr;
        if (byte_valid) begin
            case (state)
                IDLE, RUN, ERR: begin
                    if (byte_data == LOADER_HDR) begin
                        state_n    = CNT_LO;
                        xor_acc_n  = '0;
                        addr_n     = '0;
                        byte_idx_n = '0;
                    end
                end
                CNT_LO: begin
                    cnt_lo_n  = byte_data;
                    xor_acc_n = xor_acc ^ byte_data;
                    state_n   = CNT_HI;
                end
                CNT_HI: begin
                    xor_acc_n    = xor_acc ^ byte_data;
                    words_left_n = count;
                    if (count > MAX_WORDS) state_n = ERR;
                    else if (count == '0) state_n = CSUM;
                    else state_n = DATA;
                end
                DATA: begin
                    xor_acc_n  = xor_acc ^ byte_data;
                    byte_idx_n = byte_idx + 1'b1;
                    // Little-endian assembly: earlier bytes shift down toward bit 0.
                    word_asm_n = {byte_data, word_asm[23:8]};
                    if (byte_idx == 2'd3) begin
                        we_n         = 1'b1;
                        wdata_n      = {byte_data, word_asm};
                        words_left_n = words_left - 1'b1;
                        if (words_left == 17'd1) state_n = CSUM;
                    end
                end
                CSUM: begin
                    if (byte_data == xor_acc) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ERR;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (is_loading(state) && (frame_err || to_cnt == '0)) begin
            state_n = ERR;
        end
    end

    assign loader_state = state;

endmodule
